agv_mission_scheduler: RTL
==========================

Name: agv_mission_scheduler

Overview:
- Sequences the AGV's route legs: buffers a host-supplied list of waypoint nodes (pick/drop shelves) in a FIFO.
- Hands one source/destination pair at a time to the path planner and detects arrival from the tracked current node.
- Holds a fixed load/unload dwell at each waypoint, then issues the next leg.
- Returns to the home node automatically when the list is exhausted; one cycle after home is reached with the list empty, pulses mission_done.

Parameters:
- DEPTH, 8, waypoint FIFO entries; power of two, ≥2.
- NODE_W, 8, node code width; upper nibble is row, lower nibble is column.
- HOME_NODE, 8'h60, dock/start node.
- DWELL_CYCLES, 16, clk cycles spent stationary at each waypoint; ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- task_valid  in  1  host presents a waypoint.
- task_node  in  NODE_W  waypoint node code.
- task_ready  out  1  FIFO can accept (= !full).
- abort  in  1  single-cycle request: flush list, return home.
- current_node  in  NODE_W  node the AGV currently occupies.
- source  out  NODE_W  leg start node, to path planner.
- destination  out  NODE_W  leg end node, to path planner.
- route_valid  out  1  source/destination describe an active leg.
- dwelling  out  1  AGV is stationary at a waypoint.
- queue_count  out  log2(DEPTH)+1  entries in the FIFO.
- mission_done  out  1  one-cycle pulse, home reached with list empty.

Behaviour:
- Clock and reset: one clock; rst is asynchronous and active-high. All state updates on posedge clk.
- Reset values:
  - state = IDLE; source = destination = HOME_NODE.
  - route_valid = 0, dwelling = 0, mission_done = 0.
  - FIFO empty, queue_count = 0, task_ready = 1.
  - dwell counter = 0, returning flag = 0.
  - Reset mid-leg discards all queued waypoints.
- FIFO:
  - Push on task_valid && task_ready.
  - task_ready = (queue_count != DEPTH), combinational from count.
  - Push when full is ignored; no overwrite.
  - Push and pop in the same cycle: both occur, count unchanged; legal even when full.
  - Pop from empty never happens.
  - Pointers wrap modulo DEPTH.
- State machine (IDLE, TRAVEL, DWELL):
  - IDLE → TRAVEL:
    - Condition: FIFO non-empty.
    - Actions: pop head; source ← destination; destination ← head; route_valid ← 1.
    - Latency: a push into an empty FIFO in cycle N shows as the new destination in cycle N+2.
  - TRAVEL:
    - Arrival is current_node == destination, sampled each clk.
    - On arrival with returning = 0: route_valid ← 0, dwelling ← 1, counter ← DWELL_CYCLES−1, → DWELL.
    - On arrival with returning = 1: route_valid ← 0, returning ← 0, mission_done pulse next cycle, → IDLE; no dwell at home.
  - DWELL:
    - Counter decrements each cycle; dwelling stays 1 for exactly DWELL_CYCLES cycles.
    - At counter == 0 with FIFO non-empty: pop; source ← destination; destination ← head; route_valid ← 1; dwelling ← 0; → TRAVEL.
    - At counter == 0 with FIFO empty: source ← destination; destination ← HOME_NODE; returning ← 1; route_valid ← 1; dwelling ← 0; → TRAVEL.
- Waypoint equal to the current location: arrival detected the cycle after issue; the normal dwell still applies.
- HOME_NODE as a queued waypoint: treated as an ordinary waypoint, so it dwells.
- abort (highest priority, any state):
  - Flush FIFO (count → 0); a same-cycle push is dropped.
  - dwelling ← 0.
  - If current_node == HOME_NODE: route_valid ← 0 and → IDLE with mission_done pulse.
  - Otherwise: source ← current_node; destination ← HOME_NODE; returning ← 1; route_valid ← 1; → TRAVEL.
- Output timing: mission_done is exactly one cycle wide. source and destination change only on a leg issue or abort, and otherwise hold stable.
- Arithmetic: queue_count is an unsigned up/down count and never exceeds DEPTH. The dwell counter is sized by $clog2(DWELL_CYCLES).

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle. Require source = destination = 8'h60, route_valid = 0, task_ready = 1, count = 0 immediately; with no pushes the outputs stay put.
- Basic mission (DWELL_CYCLES = 4): push 8'h18, 8'h68, 8'h63.
  - Legs issued in order: (60→18), (18→68), (68→63).
  - Drive current_node to each destination in turn; dwelling is high for exactly 4 cycles at each waypoint.
  - After the 63 dwell: leg (63→60) with route_valid = 1.
  - Setting current_node = 60 gives a single mission_done pulse and IDLE.
- FIFO full (DEPTH = 8): push 9 entries while held in TRAVEL. Require task_ready = 0 after the 8th, the 9th dropped, count = 8. Simultaneous push+pop at full keeps count = 8 and accepts the new entry.
- Push/issue latency: push 8'h31 into an empty FIFO in IDLE at cycle N. Require destination = 8'h31 and route_valid = 1 at N+2.
- Abort mid-leg: in TRAVEL toward 8'h68 with 3 queued, current_node = 8'h65, pulse abort. Require count = 0, source = 65, destination = 60, route_valid = 1; arrival at 60 gives mission_done with no dwell.
- Abort at home in IDLE: with current_node = 60, pulse abort. Require route_valid = 0 and a mission_done pulse; a same-cycle task push is dropped.

Source files
------------

// File: rtl/agv_mission_scheduler.sv
// rtl/agv_mission_scheduler.sv - AGV waypoint FIFO and leg sequencer with dwell and auto-return home
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   task_valid/node   host waypoint push; task_ready = FIFO not full
//   abort             one-cycle request: flush the list and head home
//   current_node      node the AGV occupies (arrival = current_node == destination)
//   source/destination/route_valid  active leg handed to the path planner
//   dwelling          stationary load/unload at a waypoint
//   queue_count       waypoints buffered in the FIFO
//   mission_done      one-cycle pulse after home is reached with the list empty
module agv_mission_scheduler #(
  parameter int                DEPTH        = 8,
  parameter int                NODE_W       = 8,
  parameter logic [NODE_W-1:0] HOME_NODE    = 8'h60,
  parameter int                DWELL_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     task_valid,
  input  logic [NODE_W-1:0]        task_node,
  output logic                     task_ready,
  input  logic                     abort,
  input  logic [NODE_W-1:0]        current_node,
  output logic [NODE_W-1:0]        source,
  output logic [NODE_W-1:0]        destination,
  output logic                     route_valid,
  output logic                     dwelling,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     mission_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRAVEL, DWELL} state_t;

  state_t state, state_next;

  // Waypoint FIFO
  logic [NODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop;
  logic [NODE_W-1:0] head;

  logic [CW-1:0] dwell_cnt;
  logic          returning;

  // FSM decode strobes
  logic arrived, at_home, dwell_over;
  logic issue_head, issue_home, arrive_wp, arrive_home, abort_home, abort_return;

  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  assign head        = mem[rd_ptr];
  assign task_ready  = !full;
  assign queue_count = count;

  assign arrived    = (current_node == destination);
  assign at_home    = (current_node == HOME_NODE);
  assign dwell_over = (dwell_cnt == '0);

  // A full FIFO still takes a push in the cycle it pops: the freed slot is
  // the one being written, and the read sees the old entry.
  assign push = task_valid && !abort && (!full || pop);
  assign pop  = issue_head;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = at_home ? IDLE : TRAVEL;
    end else begin
      case (state)
        IDLE:    if (!empty) state_next = TRAVEL;
        TRAVEL:  if (arrived) state_next = returning ? IDLE : DWELL;
        DWELL:   if (dwell_over) state_next = TRAVEL;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: one-hot action strobes for the datapath
  always_comb begin
    issue_head   = 1'b0;
    issue_home   = 1'b0;
    arrive_wp    = 1'b0;
    arrive_home  = 1'b0;
    abort_home   = abort && at_home;
    abort_return = abort && !at_home;
    if (!abort) begin
      case (state)
        IDLE:   issue_head = !empty;
        TRAVEL: begin
          arrive_wp   = arrived && !returning;
          arrive_home = arrived && returning;
        end
        DWELL: begin
          issue_head = dwell_over && !empty;
          issue_home = dwell_over && empty;
        end
        default: ;
      endcase
    end
  end

  // FIFO storage; not reset, only the pointers and count matter
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= task_node;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Leg, dwell and completion registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      source       <= HOME_NODE;
      destination  <= HOME_NODE;
      route_valid  <= 1'b0;
      dwelling     <= 1'b0;
      mission_done <= 1'b0;
      returning    <= 1'b0;
      dwell_cnt    <= '0;
    end else begin
      mission_done <= arrive_home || abort_home;
      if (abort_return) begin
        // Replan from wherever the AGV stands right now
        source      <= current_node;
        destination <= HOME_NODE;
        returning   <= 1'b1;
        route_valid <= 1'b1;
        dwelling    <= 1'b0;
      end else if (abort_home) begin
        route_valid <= 1'b0;
        returning   <= 1'b0;
        dwelling    <= 1'b0;
      end else if (issue_head) begin
        source      <= destination;
        destination <= head;
        route_valid <= 1'b1;
        dwelling    <= 1'b0;
      end else if (issue_home) begin
        source      <= destination;
        destination <= HOME_NODE;
        returning   <= 1'b1;
        route_valid <= 1'b1;
        dwelling    <= 1'b0;
      end else if (arrive_wp) begin
        route_valid <= 1'b0;
        dwelling    <= 1'b1;
        dwell_cnt   <= DWELL_LOAD;
      end else if (arrive_home) begin
        route_valid <= 1'b0;
        returning   <= 1'b0;
      end else if (state == DWELL) begin
        dwell_cnt <= dwell_cnt - CW'(1);
      end
    end
  end

endmodule
